// File: rtl/npu_bf16_pkg.sv
// npu_bf16_pkg: BF16/FP32 field widths, biases, special-value constants and field structs
package npu_bf16_pkg;
  localparam int BF16_EXP_W = 8;
  localparam int BF16_MAN_W = 7;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int BF16_BIAS = 127;
  localparam int FP32_BIAS = 127;
  localparam int REBIAS = FP32_BIAS - BF16_BIAS;
  localparam logic [31:0] QNAN_FP32 = 32'h7FC0_0000;
  localparam logic [15:0] QNAN_BF16 = 16'h7FC0;
  localparam logic [31:0] INF_FP32 = 32'h7F80_0000;
  localparam logic [31:0] ZERO_FP32 = 32'h0000_0000;
  typedef struct packed {
    logic                  sign;
    logic [BF16_EXP_W-1:0] exp;
    logic [BF16_MAN_W-1:0] man;
  } bf16_t;
  typedef struct packed {
    logic                  sign;
    logic [FP32_EXP_W-1:0] exp;
    logic [FP32_MAN_W-1:0] man;
  } fp32_t;
endpackage

// File: rtl/fp32_add_rne.sv
// fp32_add_rne: combinational FP32 adder with RNE, FTZ and specials; in x/y, out sum and finite-overflow flag ovf
module fp32_add_rne
  import npu_bf16_pkg::*;
(
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] sum,
  output logic        ovf
);
  fp32_t fx, fy, big, sml;
  logic x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, swap, inc, finite;
  logic [7:0] d;
  logic [49:0] sh;
  logic [26:0] big_m, sml_m, norm;
  logic [27:0] raw;
  logic [4:0] lz;
  logic [24:0] rnd;
  logic signed [9:0] e, er;
  assign fx = x;
  assign fy = y;
  always_comb begin
    x_nan = &fx.exp && fx.man != '0;
    y_nan = &fy.exp && fy.man != '0;
    x_inf = &fx.exp && fx.man == '0;
    y_inf = &fy.exp && fy.man == '0;
    x_zero = fx.exp == '0;
    y_zero = fy.exp == '0;
    swap = {fy.exp, fy.man} > {fx.exp, fx.man};
    big = swap ? fy : fx;
    sml = swap ? fx : fy;
    d = big.exp - sml.exp;
    sh = {1'b1, sml.man, 26'd0} >> (d > 8'd31 ? 6'd31 : d[5:0]);
    sml_m = {sh[49:24], |sh[23:0]};
    big_m = {1'b1, big.man, 3'd0};
    raw = big.sign == sml.sign ? {1'b0, big_m} + {1'b0, sml_m} : {1'b0, big_m} - {1'b0, sml_m};
    lz = '0;
    for (int i = 0; i < 27; i++) if (raw[i]) lz = 5'(26 - i);
    norm = raw[27] ? {raw[27:2], |raw[1:0]} : raw[26:0] << lz;
    e = $signed({2'b0, big.exp}) + (raw[27] ? 10'sd1 : -$signed({5'd0, lz}));
    inc = norm[2] && (norm[3] || (|norm[1:0]));
    rnd = {1'b0, norm[26:3]} + 25'(inc);
    er = e + $signed(10'(rnd[24]));
    finite = !(x_nan || y_nan || x_inf || y_inf || x_zero || y_zero) && raw != '0;
    ovf = finite && er >= 255;
    sum = (x_nan || y_nan || (x_inf && y_inf && fx.sign != fy.sign)) ? QNAN_FP32
        : x_inf ? x : y_inf ? y
        : (x_zero && y_zero) ? {fx.sign & fy.sign, 31'd0}
        : x_zero ? y : y_zero ? x
        : raw == '0 ? ZERO_FP32
        : er >= 255 ? {big.sign, INF_FP32[30:0]}
        : er <= 0 ? {big.sign, 31'd0}
        : {big.sign, er[7:0], rnd[24] ? rnd[23:1] : rnd[22:0]};
  end
endmodule

// File: rtl/bf16_mac_stream.sv
// bf16_mac_stream: pipelined BF16 MAC, FP32 accumulate; in a/b/first/last with in_valid/in_ready, out out_data/out_ovf with out_valid/out_ready
module bf16_mac_stream
  import npu_bf16_pkg::*;
#(
  parameter bit  OUT_BF16 = 1'b0,
  parameter bit  FTZ = 1'b1,
  localparam int OUT_W = OUT_BF16 ? 16 : 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic             first,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf
);
  if (!FTZ) begin : g_ftz
    $error("bf16_mac_stream supports only FTZ=1");
  end
  bf16_t fa, fb;
  logic a_zero, b_zero, a_inf, b_inf, p_nan, p_sign, prod_ovf;
  logic [15:0] sig;
  logic signed [9:0] pe;
  logic [22:0] pm;
  logic [31:0] prod, p1, acc, sum, acc_next;
  logic en, v1, first1, last1, ovf1, acc_ovf, add_ovf, ovf_next, nan_next, bf_ovf;
  logic [15:0] bf_up, bf_res;
  logic [OUT_W-1:0] res;
  assign fa = a;
  assign fb = b;
  always_comb begin
    a_zero = fa.exp == '0;
    b_zero = fb.exp == '0;
    a_inf = &fa.exp && fa.man == '0;
    b_inf = &fb.exp && fb.man == '0;
    p_nan = (&fa.exp && fa.man != '0) || (&fb.exp && fb.man != '0) || (a_inf && b_zero) || (b_inf && a_zero);
    p_sign = fa.sign ^ fb.sign;
    sig = 16'({1'b1, fa.man}) * 16'({1'b1, fb.man});
    pe = $signed({2'b0, fa.exp} + {2'b0, fb.exp} + 10'(sig[15]) - 10'(BF16_BIAS - REBIAS));
    pm = sig[15] ? {sig[14:0], 8'd0} : {sig[13:0], 9'd0};
    prod_ovf = !p_nan && !a_inf && !b_inf && !a_zero && !b_zero && pe >= 255;
    prod = p_nan ? QNAN_FP32
         : (a_inf || b_inf || prod_ovf) ? {p_sign, INF_FP32[30:0]}
         : (a_zero || b_zero || pe <= 0) ? {p_sign, 31'd0}
         : {p_sign, pe[7:0], pm};
  end
  fp32_add_rne u_add (.x(acc), .y(p1), .sum(sum), .ovf(add_ovf));
  always_comb begin
    acc_next = first1 ? p1 : sum;
    ovf_next = first1 ? ovf1 : (acc_ovf | ovf1 | add_ovf);
    nan_next = &acc_next[30:23] && acc_next[22:0] != '0;
    bf_up = acc_next[31:16] + 16'(acc_next[15] && ((|acc_next[14:0]) || acc_next[16]));
    bf_res = nan_next ? QNAN_BF16 : bf_up;
    bf_ovf = !nan_next && &bf_up[14:7] && !(&acc_next[30:23]);
    res = OUT_BF16 ? OUT_W'(bf_res) : OUT_W'(acc_next);
  end
  assign en = !(out_valid && !out_ready);
  assign in_ready = en;
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      acc <= ZERO_FP32;
      acc_ovf <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else if (en) begin
      v1 <= in_valid;
      p1 <= prod;
      ovf1 <= prod_ovf;
      first1 <= first;
      last1 <= last;
      out_valid <= v1 && last1;
      if (v1) begin
        acc <= acc_next;
        acc_ovf <= ovf_next;
      end
      if (v1 && last1) begin
        out_data <= res;
        out_ovf <= ovf_next | (OUT_BF16 & bf_ovf);
      end
    end
  end
endmodule

// File: tb/tb_bf16_mac_stream.sv
// tb_bf16_mac_stream: directed checks of the FP32 and BF16-output MAC variants driven in lockstep
module tb_bf16_mac_stream;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, first = 1'b0, last = 1'b0, out_ready = 1'b1;
  logic [15:0] a = '0, b = '0;
  logic in_ready, out_valid, out_ovf, in_ready_bf, out_valid_bf, out_ovf_bf;
  logic [31:0] out_data;
  logic [15:0] out_data_bf;
  int tests = 0, fails = 0, hs = 0, hs0 = 0;
  bf16_mac_stream #(.OUT_BF16(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .first(first), .last(last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );
  bf16_mac_stream #(.OUT_BF16(1'b1)) dut_bf (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_bf), .a(a), .b(b),
    .first(first), .last(last), .out_valid(out_valid_bf), .out_ready(out_ready),
    .out_data(out_data_bf), .out_ovf(out_ovf_bf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (!rst && out_valid && out_ready) hs <= hs + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [15:0] x, input logic [15:0] y, input logic f, input logic l);
    in_valid = 1'b1;
    a = x;
    b = y;
    first = f;
    last = l;
    step();
  endtask
  task automatic pair(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] x1, input logic [15:0] y1);
    beat(x0, y0, 1'b1, 1'b0);
    beat(x1, y1, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
  endtask
  initial begin
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_ready", in_ready, 1);
    beat(16'h4000, 16'h4040, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("single_early", out_valid, 0);
    step();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 32'h40C0_0000);
    check("single_ovf", out_ovf, 0);
    check("single_bf", out_data_bf, 16'h40C0);
    step();
    check("single_drop", out_valid, 0);
    beat(16'h3F80, 16'h3F80, 1'b1, 1'b0);
    beat(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    beat(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    beat(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    beat(16'h3F00, 16'h4000, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("dot4_valid", out_valid, 1);
    check("dot4_data", out_data, 32'h4080_0000);
    step();
    check("next_valid", out_valid, 1);
    check("next_data", out_data, 32'h3F80_0000);
    step();
    check("stream_drop", out_valid, 0);
    out_ready = 1'b0;
    beat(16'h4000, 16'h4040, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("stall_valid", out_valid, 1);
    check("stall_ready", in_ready, 0);
    in_valid = 1'b1;
    a = 16'h7F80;
    b = 16'h0000;
    first = 1'b1;
    last = 1'b1;
    repeat (3) step();
    check("stall_hold_data", out_data, 32'h40C0_0000);
    check("stall_hold_valid", out_valid, 1);
    check("stall_hold_ready", in_ready, 0);
    hs0 = hs;
    a = 16'h3F80;
    b = 16'h3F80;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("release_drop", out_valid, 0);
    check("release_hs", hs - hs0, 1);
    step();
    check("resume_valid", out_valid, 1);
    check("resume_data", out_data, 32'h3F80_0000);
    step();
    check("resume_drop", out_valid, 0);
    check("resume_hs", hs - hs0, 2);
    beat(16'h7F80, 16'h0000, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("inf_x_zero", out_data, 32'h7FC0_0000);
    pair(16'h7F80, 16'h3F80, 16'hFF80, 16'h3F80);
    check("inf_minus_inf", out_data, 32'h7FC0_0000);
    check("inf_minus_inf_ovf", out_ovf, 0);
    beat(16'h7F7F, 16'h7F7F, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("mul_ovf_data", out_data, 32'h7F80_0000);
    check("mul_ovf_flag", out_ovf, 1);
    pair(16'h7F7F, 16'h3F80, 16'h7F7F, 16'h3F80);
    check("add_ovf_data", out_data, 32'h7F80_0000);
    check("add_ovf_flag", out_ovf, 1);
    pair(16'h7FC0, 16'h3F80, 16'h3F80, 16'h3F80);
    check("nan_sticky", out_data, 32'h7FC0_0000);
    pair(16'h3F80, 16'h3F80, 16'hBF80, 16'h3F80);
    check("cancel_zero", out_data, 32'h0000_0000);
    beat(16'h8000, 16'h3F80, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("neg_zero", out_data, 32'h8000_0000);
    pair(16'h8000, 16'h3F80, 16'h0000, 16'h3F80);
    check("mixed_zero", out_data, 32'h0000_0000);
    pair(16'h3F80, 16'h3F80, 16'h3B80, 16'h3F80);
    check("tie_fp32", out_data, 32'h3F80_8000);
    check("tie_bf", out_data_bf, 16'h3F80);
    pair(16'h3FC0, 16'h3F80, 16'h3B80, 16'h3F80);
    check("tie2_fp32", out_data, 32'h3FC0_8000);
    check("tie2_bf", out_data_bf, 16'h3FC0);
    pair(16'h3F80, 16'h3F80, 16'h3C40, 16'h3F80);
    check("tie_odd_fp32", out_data, 32'h3F81_8000);
    check("tie_odd_bf", out_data_bf, 16'h3F82);
    pair(16'h7F7F, 16'h3F80, 16'h7B00, 16'h3F80);
    check("bf_carry_fp32", out_data, 32'h7F7F_8000);
    check("bf_carry_fp32_ovf", out_ovf, 0);
    check("bf_carry_data", out_data_bf, 16'h7F80);
    check("bf_carry_ovf", out_ovf_bf, 1);
    beat(16'h3F80, 16'h3F80, 1'b1, 1'b0);
    beat(16'h3F80, 16'h3F80, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_ovf", out_ovf, 0);
    check("mid_rst_ready", in_ready, 1);
    step();
    check("mid_rst_no_emit", out_valid, 0);
    beat(16'h3F80, 16'h3F80, 1'b1, 1'b1);
    in_valid = 1'b0;
    step();
    check("post_rst_data", out_data, 32'h3F80_0000);
    beat(16'h3F80, 16'h3F80, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    check("running_sum", out_data, 32'h4000_0000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
